// File: rtl/writeback_unit.sv
// Register-file writeback: arbitrates single-cycle ALU results against a 2-deep
// mul/div result FIFO, and keeps a pending-write scoreboard for decode stalls.
module writeback_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_addr,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_addr,
   output logic        iss_ready,
   input  logic [4:0]  rAddr1,
   input  logic [4:0]  rAddr2,
   output logic        stall,
   output logic        WriteReg,
   output logic [4:0]  wAddr,
   output logic [31:0] wData,
   output logic [1:0]  fifo_count
);

   logic [1:0][4:0]  fifo_addr_q, fifo_addr_d;
   logic [1:0][31:0] fifo_data_q, fifo_data_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [1:0]       starve_q, starve_d;
   logic [31:1]      pend_q, pend_d;
   logic             write_reg_q, write_reg_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             md_src_q, md_src_d;

   logic             fifo_ne;
   logic             starved;
   logic             pop;
   logic             push;
   logic             wr_idx;
   logic [4:0]       head_addr;
   logic [31:0]      head_data;

   // Register 0 is never reserved, so its lookup is forced to zero.
   function automatic logic pend_at(input logic [31:1] pend, input logic [4:0] a);
      pend_at = (a != 5'd0) ? pend[a] : 1'b0;
   endfunction

   assign fifo_ne   = (count_q != 2'd0);
   assign starved   = (starve_q == 2'd3);
   assign pop       = fifo_ne & (~alu_valid | starved);
   assign alu_ready = alu_valid & ~starved;
   assign md_ready  = (count_q < 2'd2);
   assign push      = md_valid & md_ready;
   assign wr_idx    = rd_ptr_q ^ count_q[0];
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

   assign iss_ready  = ~pend_at(pend_q, iss_addr);
   assign stall      = pend_at(pend_q, rAddr1) | pend_at(pend_q, rAddr2);
   assign WriteReg   = write_reg_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign fifo_count = count_q;

   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      starve_d    = 2'd0;
      pend_d      = pend_q;
      write_reg_d = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      md_src_d    = 1'b0;

      if (push) begin
         fifo_addr_d[wr_idx] = md_addr;
         fifo_data_d[wr_idx] = md_data;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end

      // A non-empty FIFO that did not pop was blocked by the ALU this cycle.
      if (fifo_ne && !pop) begin
         starve_d = starve_q + 2'd1;
      end

      if (pop) begin
         write_reg_d = (head_addr != 5'd0);
         waddr_d     = head_addr;
         wdata_d     = head_data;
         md_src_d    = 1'b1;
      end else if (alu_ready) begin
         write_reg_d = (alu_addr != 5'd0);
         waddr_d     = alu_addr;
         wdata_d     = alu_data;
      end

      // Retire on the edge that ends the visible write; a new reservation wins.
      if (write_reg_q && md_src_q && (waddr_q != 5'd0)) begin
         pend_d[waddr_q] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_addr != 5'd0)) begin
         pend_d[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_addr_q <= '0;
         fifo_data_q <= '0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         starve_q    <= 2'd0;
         pend_q      <= '0;
         write_reg_q <= 1'b0;
         waddr_q     <= 5'd0;
         wdata_q     <= 32'd0;
         md_src_q    <= 1'b0;
      end else begin
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         pend_q      <= pend_d;
         write_reg_q <= write_reg_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         md_src_q    <= md_src_d;
      end
   end

endmodule
